// File: rtl/dram_ctrl_pkg.sv
// Shared types and sizing helpers for the multi-bank DRAM controller.
// Provides the access/refresh state enum, the index-width function and decode constants.
package dram_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_CAS,
    S_HOLD,
    S_NOSEL,
    S_PRE,
    S_RFSH_CAS,
    S_RFSH_RAS
  } state_e;

  // cpu_a[23:21] selects one of eight 2 MB windows
  localparam int unsigned WIN_W   = 3;
  localparam int unsigned WIN_LSB = 21;
  localparam int unsigned ROW_MSB = 20;

  // Bits needed to index n items (never less than one)
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh request generator: divider, saturating pending counter, overrun pulse.
// Ports: clk_i, rst_ni (sync), ack_i (refresh served), pending_o, overrun_o.
module dram_refresh_timer
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 110,
  parameter int unsigned PEND_MAX    = 3,
  parameter int unsigned PW          = idx_w(PEND_MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ack_i,
  output logic [PW-1:0] pending_o,
  output logic          overrun_o
);

  localparam int unsigned TW = idx_w(REFRESH_DIV);
  localparam logic [TW-1:0] T_LOAD = TW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_MAX  = PW'(PEND_MAX);

  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          reload;

  assign reload = (timer_q == '0);

  always_comb begin
    timer_d = reload ? T_LOAD : timer_q - 1'b1;
    pend_d  = pend_q;
    // a request arriving while saturated is dropped,
    // unless a service completes in the same cycle
    ovr_d   = reload && !ack_i && (pend_q == P_MAX);
    unique case ({reload, ack_i})
      2'b10: if (pend_q != P_MAX) pend_d = pend_q + 1'b1;
      2'b01: if (pend_q != '0) pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timer_q <= T_LOAD;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pending_o = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/dram_ctrl_nbank.sv
// Multi-bank 68000 fast-RAM DRAM controller: window decode, RAS/CAS access FSM,
// CAS-before-RAS refresh. Inputs: cpu_* bus strobes/address, ram_base_addr,
// ram_nconfigured. Outputs: dram_* array strobes/address, ram_ndtack,
// ram_selected, rfsh_overrun. All outputs registered.
module dram_ctrl_nbank
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BANKS       = 4,
  parameter int unsigned ROW_BITS        = 10,
  parameter int unsigned COL_BITS        = 10,
  parameter int unsigned MA_WIDTH        = 12,
  parameter int unsigned REFRESH_DIV     = 110,
  parameter int unsigned PEND_MAX        = 3,
  parameter int unsigned RFSH_RAS_CYCLES = 2
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_nreset,
  input  logic [23:1]          cpu_a,
  input  logic                 cpu_nas,
  input  logic                 cpu_nlds,
  input  logic                 cpu_nuds,
  input  logic                 cpu_rw,
  input  logic [2:0]           ram_base_addr,
  input  logic                 ram_nconfigured,
  output logic [NUM_BANKS-1:0] dram_nras,
  output logic                 dram_nlcas,
  output logic                 dram_nucas,
  output logic [MA_WIDTH-1:0]  dram_ma,
  output logic                 dram_wrn,
  output logic                 dram_oen,
  output logic                 ram_ndtack,
  output logic                 ram_selected,
  output logic                 rfsh_overrun
);

  localparam int unsigned PW = idx_w(PEND_MAX + 1);
  localparam int unsigned RW = idx_w(RFSH_RAS_CYCLES);
  localparam logic [PW-1:0] P_MAX  = PW'(PEND_MAX);
  localparam logic [RW-1:0] R_LAST = RW'(RFSH_RAS_CYCLES - 1);

  state_e               state_q;
  logic [NUM_BANKS-1:0] nras_q;
  logic                 nlcas_q;
  logic                 nucas_q;
  logic [MA_WIDTH-1:0]  ma_q;
  logic                 wrn_q;
  logic                 oen_q;
  logic                 ndtack_q;
  logic                 sel_q;
  logic                 rw_q;
  logic [RW-1:0]        rcnt_q;

  logic [WIN_W-1:0]     bank_off;
  logic                 hit;
  logic                 start_acc;
  logic [NUM_BANKS-1:0] bank_mask;
  logic [MA_WIDTH-1:0]  row_ma;
  logic [MA_WIDTH-1:0]  col_ma;
  logic [PW-1:0]        pending;
  logic                 rfsh_ack;

  // 3-bit wrap lets the window straddle the top of the map
  assign bank_off = cpu_a[WIN_LSB+WIN_W-1:WIN_LSB] - ram_base_addr;
  assign hit = !ram_nconfigured &&
               ({1'b0, bank_off} < 4'(NUM_BANKS));
  assign start_acc = !cpu_nas && hit && (pending < P_MAX);
  assign bank_mask = NUM_BANKS'(1) << bank_off;

  always_comb begin
    row_ma = '0;
    col_ma = '0;
    row_ma[ROW_BITS-1:0] = cpu_a[ROW_MSB -: ROW_BITS];
    col_ma[COL_BITS-1:0] = cpu_a[COL_BITS:1];
  end

  assign rfsh_ack = (state_q == S_RFSH_RAS) && (rcnt_q == R_LAST);

  dram_refresh_timer #(
    .REFRESH_DIV(REFRESH_DIV),
    .PEND_MAX   (PEND_MAX),
    .PW         (PW)
  ) u_rfsh (
    .clk_i    (cpu_clk),
    .rst_ni   (cpu_nreset),
    .ack_i    (rfsh_ack),
    .pending_o(pending),
    .overrun_o(rfsh_overrun)
  );

  always_ff @(posedge cpu_clk) begin
    if (!cpu_nreset) begin
      state_q  <= S_IDLE;
      nras_q   <= '1;
      nlcas_q  <= 1'b1;
      nucas_q  <= 1'b1;
      ma_q     <= '0;
      wrn_q    <= 1'b1;
      oen_q    <= 1'b1;
      ndtack_q <= 1'b1;
      sel_q    <= 1'b0;
      rw_q     <= 1'b1;
      rcnt_q   <= '0;
    end else begin
      unique case (state_q)
        // PRE decides like IDLE so a waiting access
        // starts straight after precharge
        S_IDLE, S_PRE: begin
          if (start_acc) begin
            state_q <= S_ROW;
            rw_q    <= cpu_rw;
            nras_q  <= ~bank_mask;
            ma_q    <= row_ma;
            sel_q   <= 1'b1;
          end else if (!cpu_nas && !hit) begin
            state_q <= S_NOSEL;
          end else if (pending != '0) begin
            state_q <= S_RFSH_CAS;
            nlcas_q <= 1'b0;
            nucas_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ROW: begin
          state_q <= S_COL;
          ma_q    <= col_ma;
          wrn_q   <= rw_q;
        end
        S_COL: begin
          state_q  <= S_CAS;
          nlcas_q  <= cpu_nlds;
          nucas_q  <= cpu_nuds;
          ndtack_q <= 1'b0;
          oen_q    <= ~rw_q;
        end
        S_CAS: begin
          state_q <= S_HOLD;
          nlcas_q <= cpu_nlds;
          nucas_q <= cpu_nuds;
        end
        S_HOLD: begin
          if (cpu_nas) begin
            state_q  <= S_PRE;
            nras_q   <= '1;
            nlcas_q  <= 1'b1;
            nucas_q  <= 1'b1;
            wrn_q    <= 1'b1;
            oen_q    <= 1'b1;
            ndtack_q <= 1'b1;
            sel_q    <= 1'b0;
          end else begin
            nlcas_q <= cpu_nlds;
            nucas_q <= cpu_nuds;
          end
        end
        S_NOSEL: begin
          if (cpu_nas) state_q <= S_IDLE;
        end
        S_RFSH_CAS: begin
          // /CAS stays low while /RAS falls so the
          // array sees CAS-before-RAS with hold margin
          state_q <= S_RFSH_RAS;
          nras_q  <= '0;
          rcnt_q  <= '0;
        end
        S_RFSH_RAS: begin
          if (rcnt_q == R_LAST) begin
            state_q <= S_PRE;
            nras_q  <= '1;
            nlcas_q <= 1'b1;
            nucas_q <= 1'b1;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dram_nras    = nras_q;
  assign dram_nlcas   = nlcas_q;
  assign dram_nucas   = nucas_q;
  assign dram_ma      = ma_q;
  assign dram_wrn     = wrn_q;
  assign dram_oen     = oen_q;
  assign ram_ndtack   = ndtack_q;
  assign ram_selected = sel_q;

endmodule

// File: tb/tb_dram_ctrl_nbank.sv
// Scoreboard bench for dram_ctrl_nbank: directed accesses, no-select windows,
// refresh saturation/overrun, refresh-before-access and reset during HOLD.
module tb_dram_ctrl_nbank;

  localparam int DIV = 110;

  logic        clk = 1'b0;
  logic        nreset;
  logic [23:1] cpu_a;
  logic        nas, nlds, nuds, rw;
  logic [2:0]  base;
  logic        ncfg;
  logic [3:0]  nras;
  logic        nlcas, nucas;
  logic [11:0] ma;
  logic        wrn, oen, ndtack, sel, ovr;

  always #5 clk = ~clk;

  dram_ctrl_nbank dut (
    .cpu_clk        (clk),
    .cpu_nreset     (nreset),
    .cpu_a          (cpu_a),
    .cpu_nas        (nas),
    .cpu_nlds       (nlds),
    .cpu_nuds       (nuds),
    .cpu_rw         (rw),
    .ram_base_addr  (base),
    .ram_nconfigured(ncfg),
    .dram_nras      (nras),
    .dram_nlcas     (nlcas),
    .dram_nucas     (nucas),
    .dram_ma        (ma),
    .dram_wrn       (wrn),
    .dram_oen       (oen),
    .ram_ndtack     (ndtack),
    .ram_selected   (sel),
    .rfsh_overrun   (ovr)
  );

  typedef struct {
    logic [23:0] addr;
    logic [2:0]  base;
    logic        rw, nuds, nlds;
    logic [3:0]  nras;
    logic [11:0] row, col;
    logic        nl, nu, wrn, oen;
    int          lat;
  } vec_t;

  vec_t q[$];
  vec_t vec[5];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: samples 1 ns after each rising edge
  logic [3:0]  p_nras = '1;
  logic        p_dtack = 1'b1;
  int          nas_cnt = 0;
  int          age = 100;
  logic [3:0]  m_mask;
  logic [11:0] m_row;
  logic        m_wrn_col;

  always @(posedge clk) begin
    vec_t e;
    #1;
    nas_cnt = nas ? 0 : nas_cnt + 1;
    if (p_nras == 4'hF && nras != 4'hF && nras != 4'h0) begin
      m_mask = nras;
      m_row  = ma;
      age    = 0;
    end else if (age < 100) begin
      age++;
    end
    if (age == 1) m_wrn_col = wrn;
    if (p_dtack && !ndtack) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dtack: got 0 expected 1");
      end else begin
        e = q.pop_front();
        chk("ras_bank", m_mask, e.nras);
        chk("nras_at_cas", nras, e.nras);
        chk("row", m_row, e.row);
        chk("col", ma, e.col);
        chk("nlcas", nlcas, e.nl);
        chk("nucas", nucas, e.nu);
        chk("wrn_col", m_wrn_col, e.wrn);
        chk("wrn_cas", wrn, e.wrn);
        chk("oen", oen, e.oen);
        chk("latency", nas_cnt - 1, e.lat);
        chk("selected", sel, 1);
      end
    end
    if (!p_dtack && nas && nreset) chk("dtack_release", ndtack, 1);
    p_nras  = nras;
    p_dtack = ndtack;
  end

  task automatic do_reset();
    nreset = 1'b0;
    nas = 1'b1; nlds = 1'b1; nuds = 1'b1; rw = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic start(input vec_t v);
    q.push_back(v);
    base  = v.base;
    cpu_a = v.addr[23:1];
    rw    = v.rw;
    nuds  = v.nuds;
    nlds  = v.nlds;
    nas   = 1'b0;
  endtask

  task automatic wait_dtack(input string nm);
    int n = 0;
    while (ndtack !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ndtack !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got 1 expected 0", nm);
    end
  endtask

  task automatic access(input vec_t v);
    start(v);
    @(negedge clk);
    wait_dtack("access");
    @(negedge clk);
    nas = 1'b1; nlds = 1'b1; nuds = 1'b1; rw = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic nosel(input logic [23:0] a, input logic [2:0] b,
                       input logic nc, input string nm);
    logic bad = 1'b0;
    base = b; ncfg = nc; cpu_a = a[23:1]; rw = 1'b1;
    nlds = 1'b0; nuds = 1'b0; nas = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (nras != 4'hF || !nlcas || !nucas || !ndtack || sel ||
          !wrn || !oen) bad = 1'b1;
    end
    nas = 1'b1; nlds = 1'b1; nuds = 1'b1;
    repeat (3) @(negedge clk);
    chk(nm, bad, 0);
    ncfg = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ovr_n, low_n, starts, cas_n, rf;
    logic [3:0] pn;
    vec_t v;
    ncfg = 1'b0; base = 3'd1; cpu_a = '0;
    //        addr       base rw nuds nlds nras  row     col     nl nu wrn oen lat
    vec[0] = '{24'h200000, 3'd1, 1'b1, 1'b0, 1'b0, 4'b1110,
               12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vec[1] = '{24'h5FFFFF, 3'd1, 1'b0, 1'b1, 1'b0, 4'b1101,
               12'h3FF, 12'h3FF, 1'b0, 1'b1, 1'b0, 1'b1, 2};
    vec[2] = '{24'h3ABCDE, 3'd1, 1'b1, 1'b0, 1'b0, 4'b1110,
               12'h357, 12'h26F, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vec[3] = '{24'h400002, 3'd7, 1'b1, 1'b0, 1'b1, 4'b0111,
               12'h000, 12'h001, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    vec[4] = '{24'h1FFFFE, 3'd7, 1'b0, 1'b0, 1'b0, 4'b1101,
               12'h3FF, 12'h3FF, 1'b0, 1'b0, 1'b0, 1'b1, 2};

    do_reset();
    nreset = 1'b0;
    @(negedge clk);
    chk("rst_nras", nras, 4'hF);
    chk("rst_cas", {nlcas, nucas}, 2'b11);
    chk("rst_wrn_oen", {wrn, oen}, 2'b11);
    chk("rst_dtack", ndtack, 1);
    chk("rst_sel", sel, 0);
    chk("rst_ma", ma, 0);
    chk("rst_ovr", ovr, 0);
    nreset = 1'b1;

    foreach (vec[i]) access(vec[i]);

    do_reset();
    nosel(24'hA00000, 3'd1, 1'b0, "nosel_window");
    nosel(24'h200000, 3'd1, 1'b1, "nosel_unconfigured");

    // Saturate pending with cpu_nas held on an unmapped address
    do_reset();
    base = 3'd1; cpu_a = 23'h500000; nas = 1'b0;
    ovr_n = 0;
    repeat (4 * DIV + 5) begin
      @(negedge clk);
      if (ovr) ovr_n++;
    end
    chk("overrun_pulses", ovr_n, 1);
    nas = 1'b1;
    low_n = 0; starts = 0; cas_n = 0; pn = 4'hF;
    repeat (30) begin
      @(negedge clk);
      if (nras == 4'h0) low_n++;
      if (nras == 4'h0 && pn != 4'h0) starts++;
      if (nras == 4'hF && !nlcas && !nucas) cas_n++;
      pn = nras;
    end
    chk("refresh_count", starts, 3);
    chk("refresh_ras_cycles", low_n, 6);
    chk("refresh_cbr_cas", cas_n, 3);

    // pending=3 then access: refresh first, dtack after 6 edges
    do_reset();
    base = 3'd1; cpu_a = 23'h500000; nas = 1'b0;
    repeat (3 * DIV + 5) @(negedge clk);
    nas = 1'b1;
    @(negedge clk);
    v = vec[0];
    v.lat = 6;
    start(v);
    @(negedge clk);
    wait_dtack("rfsh_first");
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    chk("hold_rst_nras", nras, 4'hF);
    chk("hold_rst_cas", {nlcas, nucas}, 2'b11);
    chk("hold_rst_dtack", ndtack, 1);
    chk("hold_rst_wrn_oen", {wrn, oen}, 2'b11);
    chk("hold_rst_sel", sel, 0);
    nas = 1'b1; nlds = 1'b1; nuds = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    rf = 0;
    repeat (DIV - 10) begin
      @(negedge clk);
      if (nras == 4'h0) rf++;
    end
    chk("pending_cleared", rf, 0);
    access(vec[1]);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_ctrl_nbank.md
# dram_ctrl_nbank

Parametrised multi-bank DRAM controller for the Amiga 68000 expansion bus; next generation of the 8 MB fast-RAM controller. Decodes a contiguous window of NUM_BANKS DRAM banks at a configurable base, runs a fully synchronous RAS/CAS access state machine with per-bank /RAS and byte /CAS, and schedules CAS-before-RAS refresh from an internal timer with a bounded backlog. Sits between the CPU bus pins and the DRAM array, alongside the autoconfig logic that supplies the base and configured flag.

## Interface
Parameters:
- NUM_BANKS, 4, number of banks; one /RAS line each (1..8)
- ROW_BITS, 10, row address bits per bank
- COL_BITS, 10, column address bits per bank (bank size = 2^(ROW_BITS+COL_BITS+1) bytes; ROW_BITS+COL_BITS must be 20)
- MA_WIDTH, 12, DRAM address pins; must be >= max(ROW_BITS, COL_BITS); unused upper bits driven 0
- REFRESH_DIV, 110, cpu_clk cycles per refresh request
- PEND_MAX, 3, saturation limit of pending-refresh counter
- RFSH_RAS_CYCLES, 2, /RAS low cycles in a refresh

Ports:
- cpu_clk  in  1  bus clock; sole clock
- cpu_nreset  in  1  synchronous, active-low reset
- cpu_a  in  23  CPU address [23:1]
- cpu_nas, cpu_nlds, cpu_nuds, cpu_rw  in  1 each  68000 strobes, sampled on rising cpu_clk
- ram_base_addr  in  3  window base, compared with cpu_a[23:21]
- ram_nconfigured  in  1  high: decode disabled, no access starts
- dram_nras  out  NUM_BANKS  per-bank /RAS
- dram_nlcas, dram_nucas  out  1 each  byte /CAS
- dram_ma  out  MA_WIDTH  multiplexed address
- dram_wrn, dram_oen  out  1 each  DRAM /WE, /OE
- ram_ndtack  out  1  /DTACK contribution
- ram_selected  out  1  current cycle targets this block
- rfsh_overrun  out  1  one-cycle pulse: refresh request lost

## Operation
- Decode: bank = cpu_a[23:21] − ram_base_addr (3-bit wrap); hit when ram_nconfigured=0 and bank < NUM_BANKS. Row = cpu_a[20:21−ROW_BITS], column = cpu_a[COL_BITS:1].
- States: IDLE, ROW, COL, CAS, HOLD, NOSEL, PRE, RFSH_CAS, RFSH_RAS.
- IDLE: cpu_nas=0 and hit and pending<PEND_MAX → ROW (latch bank, rw). cpu_nas=0, no hit → NOSEL. Else pending>0 → RFSH_CAS. pending=PEND_MAX with cpu_nas=0 → RFSH_CAS first; access starts after PRE.
- ROW: selected bank /RAS low, row on dram_ma; → COL.
- COL: column on dram_ma; write cycles drive dram_wrn=0 (early write); → CAS.
- CAS: /CAS low per latched ~nlds/~nuds (re-sampled each cycle in CAS/HOLD), ram_ndtack=0, read cycles dram_oen=0; → HOLD.
- HOLD: hold strobes until cpu_nas sampled 1 → PRE (all strobes high, wrn/oen high).
- NOSEL: no outputs change; cpu_nas=1 → IDLE.
- PRE: one cycle precharge; → IDLE.
- RFSH_CAS: both /CAS low one cycle; → RFSH_RAS. RFSH_RAS: all /RAS low RFSH_RAS_CYCLES cycles, then → PRE, pending−1.
- Timer counts REFRESH_DIV−1 down to 0 and reloads; at reload pending+1, saturating. Reload when pending=PEND_MAX pulses rfsh_overrun. Reload and service completion in same cycle: pending unchanged.
- ram_selected = 1 from ROW through HOLD.

## Timing
- All outputs registered. Reset values: dram_nras all 1, dram_nlcas/nucas 1, dram_wrn 1, dram_oen 1, ram_ndtack 1, ram_selected 0, dram_ma 0, rfsh_overrun 0; state IDLE, pending 0, timer REFRESH_DIV−1.
- Access latency: cpu_nas sampled low at edge N → /RAS low after N, column after N+1, /CAS and ram_ndtack low after N+2.
- ram_ndtack returns high the edge cpu_nas is sampled high.
- Refresh occupies 1+RFSH_RAS_CYCLES+1 cycles; access arriving meanwhile waits, ram_ndtack high.
- Reset mid-cycle: all strobes high on the next edge regardless of state; tRAS violation accepted.

## Structure
- Package dram_ctrl_pkg: state enum, bank-index width function, decode-width constants.
- Sub-module dram_refresh_timer: divider, saturating pending counter, overrun pulse, service-ack input.

## Test plan
- Read at $200000, base=1 → dram_nras[0] low after edge N, /CAS both low and ram_ndtack low after N+2, dram_oen=0, dram_wrn=1.
- Byte write to $5FFFFF (nlds=0, nuds=1), base=1 → dram_nras[1] low, only dram_nlcas low, dram_wrn=0 from COL, row 0x3FF, column 0x3FF.
- Address $A00000 with NUM_BANKS=4, base=1 → NOSEL, no strobe, ram_ndtack stays 1; ram_nconfigured=1 at $200000 → same.
- Hold cpu_nas low 4×REFRESH_DIV cycles → pending saturates at 3, rfsh_overrun one pulse; on release three back-to-back refreshes, all /RAS low 2 cycles each.
- pending=3, cpu_nas falls at $200000 → refresh completes first; ram_ndtack low exactly 6 cycles after cpu_nas sampled low.
- cpu_nreset low during HOLD → next edge all strobes high, state IDLE, pending 0.
